// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path.
// Holds the instruction opcodes, the ALU op encodings (shared with the ALU),
// the sequencer state type and the instruction field bit positions.
package cpu_pkg;

  // Instruction opcodes, IR[7:5]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_LDI  = 3'b100;
  localparam logic [2:0] OP_BEQZ = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // ALU op encodings driven on alu_op
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Instruction field bit positions; bit 4 carries no meaning
  localparam int unsigned IR_OPC_MSB = 7;
  localparam int unsigned IR_OPC_LSB = 5;
  localparam int unsigned IR_RD_MSB  = 3;
  localparam int unsigned IR_RD_LSB  = 2;
  localparam int unsigned IR_RS_MSB  = 1;
  localparam int unsigned IR_RS_LSB  = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_FETCH_IMM,
    ST_HALT
  } state_t;

  // Decoded instruction register; the ignored bit is not stored
  typedef struct packed {
    logic [2:0] opc;
    logic [1:0] rd;
    logic [1:0] rs;
  } instr_t;

  function automatic logic is_alu_op(input logic [2:0] opc);
    return opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// 4 x 8-bit register file.
// Ports: clk/rst (sync active-high reset clears all registers),
//        i_we/i_waddr/i_wdata  synchronous write port,
//        i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b  combinational read ports,
//        i_dbg_sel/o_dbg_data  combinational debug read port.
module regfile4x8 #(
  parameter int unsigned NUM_REGS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic [1:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [1:0] i_raddr_a,
  output logic [7:0] o_rdata_a,
  input  logic [1:0] i_raddr_b,
  output logic [7:0] o_rdata_b,
  input  logic [1:0] i_dbg_sel,
  output logic [7:0] o_dbg_data
);

  logic [7:0] r_regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_regs[i_raddr_a];
  assign o_rdata_b  = r_regs[i_raddr_b];
  assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multicycle control sequencer for the 8-bit CPU.
// Fetches instructions over a req/ready handshake, decodes them, drives the
// ALU operands/op and writes the ALU result and zero flag back. Handles LDI,
// JMP, BEQZ and HALT.
// Ports: clk, rst (sync, active-high)
//        mem_addr/mem_req/mem_rdata/mem_ready  instruction fetch handshake
//        alu_a/alu_b/alu_op -> ALU, alu_result/alu_zero <- ALU
//        halted  core stopped in HALT
//        dbg_sel/dbg_data  combinational register observation
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] mem_addr,
  output logic       mem_req,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       halted,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  instr_t     r_ir, w_ir_nxt;
  logic       r_z, w_z_nxt;
  logic       w_we;
  logic [7:0] w_wdata;
  logic       w_req;
  logic [2:0] w_alu_op;
  logic       w_halted;

  regfile4x8 #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_waddr    (r_ir.rd),
    .i_wdata    (w_wdata),
    .i_raddr_a  (r_ir.rd),
    .o_rdata_a  (alu_a),
    .i_raddr_b  (r_ir.rs),
    .o_rdata_b  (alu_b),
    .i_dbg_sel  (dbg_sel),
    .o_dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_z     <= w_z_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_z_nxt     = r_z;
    w_we        = 1'b0;
    w_wdata     = '0;
    w_req       = 1'b0;
    w_alu_op    = ALU_ADD;
    w_halted    = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        w_req = 1'b1;
        if (mem_ready) begin
          w_ir_nxt.opc = mem_rdata[IR_OPC_MSB:IR_OPC_LSB];
          w_ir_nxt.rd  = mem_rdata[IR_RD_MSB:IR_RD_LSB];
          w_ir_nxt.rs  = mem_rdata[IR_RS_MSB:IR_RS_LSB];
          w_pc_nxt     = r_pc + 8'd1;
          w_state_nxt  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_alu_op(r_ir.opc)) begin
          w_state_nxt = ST_EXEC;
        end else begin
          unique case (r_ir.opc)
            OP_LDI, OP_JMP: w_state_nxt = ST_FETCH_IMM;
            OP_BEQZ: begin
              if (r_z) begin
                w_state_nxt = ST_FETCH_IMM;
              end else begin
                // Not taken: step over the target byte without fetching it
                w_pc_nxt    = r_pc + 8'd1;
                w_state_nxt = ST_FETCH;
              end
            end
            default: w_state_nxt = ST_HALT;
          endcase
        end
      end
      ST_EXEC: begin
        w_alu_op    = r_ir.opc;
        w_state_nxt = ST_WB;
      end
      ST_WB: begin
        // Operands come straight from the regfile, so they stay stable until
        // this write lands at the end of the cycle.
        w_alu_op    = r_ir.opc;
        w_we        = 1'b1;
        w_wdata     = alu_result;
        w_z_nxt     = alu_zero;
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH_IMM: begin
        w_req = 1'b1;
        if (mem_ready) begin
          if (r_ir.opc == OP_LDI) begin
            w_we     = 1'b1;
            w_wdata  = mem_rdata;
            w_pc_nxt = r_pc + 8'd1;
          end else begin
            w_pc_nxt = mem_rdata;
          end
          w_state_nxt = ST_FETCH;
        end
      end
      ST_HALT: begin
        w_halted = 1'b1;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  assign mem_addr = r_pc;
  assign mem_req  = w_req & ~rst;
  assign alu_op   = w_alu_op;
  assign halted   = w_halted;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
module tb_cpu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       halted;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  logic [7:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  // ALU: 000 ADD, 001 SUB, 010 AND, 011 OR
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      default: alu_result = 8'h00;
    endcase
  end
  assign alu_zero = (alu_result == 8'h00);

  cpu_ctrl_seq #(.RESET_PC(8'h00), .NUM_REGS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .halted     (halted),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // exp holds {R0,R1,R2,R3}; called just after a falling edge
  task automatic chk_regs(input string name, input logic [31:0] exp);
    logic [1:0] keep;
    keep = dbg_sel;
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("%s_R%0d", name, i), {24'h0, dbg_data}, {24'h0, exp[31-8*i -: 8]});
    end
    dbg_sel = keep;
  endtask

  // Bytes 0..7 from prog (MSB first), everything else HALT, plus one patch byte
  task automatic load_prog(input logic [63:0] prog, input logic [7:0] pa, input logic [7:0] pd);
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    for (int i = 0; i < 8; i++) mem[i] = prog[63-8*i -: 8];
    mem[pa] = pd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [63:0] prog;
    logic [7:0]  pa;
    logic [7:0]  pd;
    logic [7:0]  ncyc;
    logic [7:0]  addr;
    logic        req;
    logic        hlt;
    logic [31:0] regs;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // ISA-level reference model
  logic [7:0] m_regs [4];
  logic [7:0] m_pc;
  logic       m_z;
  logic       m_op;      // next accepted fetch is an opcode fetch
  logic       m_halted;
  logic [2:0] m_opc;
  logic [1:0] m_rd;
  int         m_ops;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_pc = 8'h00; m_z = 1'b0; m_op = 1'b1; m_halted = 1'b0;
    m_opc = 3'd0; m_rd = 2'd0; m_ops = 0;
  endtask

  task automatic model_accept();
    logic [7:0] b, a, c, r;
    logic [1:0] rs;
    if (m_op) begin
      b = mem[m_pc];
      m_pc = m_pc + 8'd1;
      m_ops++;
      m_opc = b[7:5]; m_rd = b[3:2]; rs = b[1:0];
      case (m_opc)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          a = m_regs[m_rd]; c = m_regs[rs];
          case (m_opc)
            3'd0:    r = a + c;
            3'd1:    r = a - c;
            3'd2:    r = a & c;
            default: r = a | c;
          endcase
          m_regs[m_rd] = r;
          m_z = (r == 8'h00);
        end
        3'd4, 3'd6: m_op = 1'b0;
        3'd5: if (m_z) m_op = 1'b0; else m_pc = m_pc + 8'd1;
        default: m_halted = 1'b1;
      endcase
    end else begin
      if (m_opc == 3'd4) begin
        m_regs[m_rd] = mem[m_pc];
        m_pc = m_pc + 8'd1;
      end else begin
        m_pc = mem[m_pc];
      end
      m_op = 1'b1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; dbg_sel = 2'd0;
    load_prog(64'hE0E0E0E0E0E0E0E0, 8'hFF, 8'hE0);

    vecs[0]  = '{64'h80_05_84_03_21_E0_E0_E0, 8'hFF, 8'hE0, 8'd10, 8'h05, 1'b1, 1'b0, 32'h02_03_00_00};
    vecs[1]  = '{64'h80_05_84_03_21_A0_10_E0, 8'hFF, 8'hE0, 8'd12, 8'h07, 1'b1, 1'b0, 32'h02_03_00_00};
    vecs[2]  = '{64'h80_05_84_03_21_25_A0_10, 8'hFF, 8'hE0, 8'd17, 8'h10, 1'b1, 1'b0, 32'h02_00_00_00};
    vecs[3]  = '{64'h80_05_84_03_21_25_A0_10, 8'hFF, 8'hE0, 8'd18, 8'h11, 1'b0, 1'b0, 32'h02_00_00_00};
    vecs[4]  = '{64'h80_05_84_03_21_25_A0_10, 8'hFF, 8'hE0, 8'd19, 8'h11, 1'b0, 1'b1, 32'h02_00_00_00};
    vecs[5]  = '{64'h80_05_84_03_21_25_A0_10, 8'hFF, 8'hE0, 8'd30, 8'h11, 1'b0, 1'b1, 32'h02_00_00_00};
    vecs[6]  = '{64'hA0_20_E0_E0_E0_E0_E0_E0, 8'hFF, 8'hE0, 8'd1,  8'h01, 1'b0, 1'b0, 32'h00_00_00_00};
    vecs[7]  = '{64'hA0_20_E0_E0_E0_E0_E0_E0, 8'hFF, 8'hE0, 8'd2,  8'h02, 1'b1, 1'b0, 32'h00_00_00_00};
    vecs[8]  = '{64'h25_80_07_C0_06_E0_A0_30, 8'hFF, 8'hE0, 8'd13, 8'h30, 1'b1, 1'b0, 32'h07_00_00_00};
    vecs[9]  = '{64'h80_05_84_09_C0_FF_E0_E0, 8'hFF, 8'h01, 8'd10, 8'h00, 1'b0, 1'b0, 32'h05_09_00_00};
    vecs[10] = '{64'h80_05_84_09_C0_FF_E0_E0, 8'hFF, 8'h01, 8'd13, 8'h00, 1'b1, 1'b0, 32'h0E_09_00_00};
    vecs[11] = '{64'h80_0C_84_0A_41_6D_E0_E0, 8'hFF, 8'hE0, 8'd14, 8'h06, 1'b1, 1'b0, 32'h08_0A_00_0A};
    vecs[12] = '{64'h88_81_0A_E0_E0_E0_E0_E0, 8'hFF, 8'hE0, 8'd7,  8'h03, 1'b1, 1'b0, 32'h00_00_02_00};
    vecs[13] = '{64'h80_05_84_03_24_E0_E0_E0, 8'hFF, 8'hE0, 8'd10, 8'h05, 1'b1, 1'b0, 32'h05_FE_00_00};
    vecs[14] = '{64'hE0_E0_E0_E0_E0_E0_E0_E0, 8'hFF, 8'hE0, 8'd2,  8'h01, 1'b0, 1'b1, 32'h00_00_00_00};

    // ---- table-driven vectors, zero wait states ----
    for (int v = 0; v < NV; v++) begin
      load_prog(vecs[v].prog, vecs[v].pa, vecs[v].pd);
      mem_ready = 1'b1;
      do_reset();
      repeat (int'(vecs[v].ncyc)) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_addr", v), {24'h0, mem_addr}, {24'h0, vecs[v].addr});
      chk($sformatf("v%0d_req", v), {31'h0, mem_req}, {31'h0, vecs[v].req});
      chk($sformatf("v%0d_halted", v), {31'h0, halted}, {31'h0, vecs[v].hlt});
      chk_regs($sformatf("v%0d", v), vecs[v].regs);
    end

    // ---- reset state and ALU drive through EXEC/WB ----
    load_prog(64'h80_05_84_03_21_E0_E0_E0, 8'hFF, 8'hE0);
    mem_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("rst_alu_op", {29'h0, alu_op}, 32'h0);
    chk("rst_alu_a", {24'h0, alu_a}, 32'h0);
    chk("rst_alu_b", {24'h0, alu_b}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h1);
    chk("rst_addr", {24'h0, mem_addr}, 32'h0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("exec_op", {29'h0, alu_op}, 32'h1);
    chk("exec_a", {24'h0, alu_a}, 32'h05);
    chk("exec_b", {24'h0, alu_b}, 32'h03);
    @(posedge clk); @(negedge clk);
    chk("wb_op", {29'h0, alu_op}, 32'h1);
    chk("wb_a", {24'h0, alu_a}, 32'h05);
    chk("wb_b", {24'h0, alu_b}, 32'h03);
    @(posedge clk); @(negedge clk);
    chk("post_wb_op", {29'h0, alu_op}, 32'h0);
    chk("post_wb_a", {24'h0, alu_a}, 32'h02);

    // ---- wait states on opcode and immediate fetch ----
    load_prog(64'h88_A5_E0_E0_E0_E0_E0_E0, 8'hFF, 8'hE0);
    mem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("ws_op%0d_req", i), {31'h0, mem_req}, 32'h1);
      chk($sformatf("ws_op%0d_addr", i), {24'h0, mem_addr}, 32'h0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("ws_dec_addr", {24'h0, mem_addr}, 32'h1);
    chk("ws_dec_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("ws_imm%0d_req", i), {31'h0, mem_req}, 32'h1);
      chk($sformatf("ws_imm%0d_addr", i), {24'h0, mem_addr}, 32'h1);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ws_done_addr", {24'h0, mem_addr}, 32'h2);
    chk_regs("ws_done", 32'h00_00_A5_00);

    // ---- reset during a stalled immediate fetch ----
    load_prog(64'h84_11_88_22_2A_80_44_E0, 8'hFF, 8'hE0);
    mem_ready = 1'b1;
    do_reset();
    repeat (11) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mid_req", {31'h0, mem_req}, 32'h1);
    chk("mid_addr", {24'h0, mem_addr}, 32'h6);
    chk_regs("mid_pre", 32'h00_11_00_00);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_req2", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_post_addr", {24'h0, mem_addr}, 32'h0);
    chk("mid_post_req", {31'h0, mem_req}, 32'h1);
    chk("mid_post_halted", {31'h0, halted}, 32'h0);
    chk_regs("mid_post", 32'h0);
    // Z must be clear again: BEQZ is not taken
    mem[0] = 8'hA0; mem[1] = 8'h20;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_post_z", {24'h0, mem_addr}, 32'h2);

    // ---- reset out of HALT ----
    load_prog(64'hE0_E0_E0_E0_E0_E0_E0_E0, 8'hFF, 8'hE0);
    mem_ready = 1'b1;
    do_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("hlt_halted", {31'h0, halted}, 32'h1);
    chk("hlt_req", {31'h0, mem_req}, 32'h0);
    chk("hlt_addr", {24'h0, mem_addr}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("hlt_rst_halted", {31'h0, halted}, 32'h0);
    chk("hlt_rst_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("hlt_post_addr", {24'h0, mem_addr}, 32'h0);
    chk("hlt_post_req", {31'h0, mem_req}, 32'h1);

    // ---- random programs, random wait states, ISA model ----
    for (int rnd = 0; rnd < 20; rnd++) begin
      bit done;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem_ready = 1'b1;
      do_reset();
      model_reset();
      done = 1'b0;
      for (int cyc = 0; cyc < 1500 && !done; cyc++) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        dbg_sel = 2'($urandom_range(0, 3));
        @(negedge clk);
        if (mem_req && mem_ready) begin
          if (m_halted) begin
            chk($sformatf("rnd%0d_fetch_after_halt", rnd), 32'h1, 32'h0);
          end else begin
            chk($sformatf("rnd%0d_addr", rnd), {24'h0, mem_addr}, {24'h0, m_pc});
            if (m_op)
              chk($sformatf("rnd%0d_R%0d", rnd, dbg_sel), {24'h0, dbg_data}, {24'h0, m_regs[dbg_sel]});
            model_accept();
          end
        end
        if (halted) begin
          chk($sformatf("rnd%0d_halt", rnd), {31'h0, m_halted}, 32'h1);
          chk($sformatf("rnd%0d_halt_req", rnd), {31'h0, mem_req}, 32'h0);
          done = 1'b1;
        end else if (m_op && m_ops >= 60) begin
          done = 1'b1;
        end
        @(posedge clk); #1;
      end
      if (!done) chk($sformatf("rnd%0d_budget", rnd), 32'h0, 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
